piso_serializer: RTL and testbench

- Parallel-in/serial-out transmitter: the transmit end of the single-bit serial link whose receive end is the bidirectional serial-in shift register.
- Accepts an N-bit word through a valid/ready load handshake, then emits it one bit per clock on sout, MSB-first or LSB-first.
- Flags each valid bit and pulses done on the final bit of every frame.
- Supports back-to-back frames with no idle gap.

---
 rtl/piso_serializer.sv | 163 ++++++++++++++++
 tb/tb_piso_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out transmitter. A word is taken through a
//   valid/ready load handshake. It is then sent one bit per clock on sout,
//   either MSB-first or LSB-first. The order is chosen by msb_first at accept
//   time.
//
//   The first bit appears in the cycle right after the accept edge. done
//   pulses on the last bit of each frame. A new word may be accepted during
//   that last-bit cycle, so back-to-back frames run with no idle gap.
//
//   Optional feature (macro PISO_PARITY_EN):
//     When defined, an even-parity bit (XOR of the data bits) is captured at
//     accept time. It is sent after the last data bit, so a frame is N+1
//     bits long.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din[N-1:0]  in   parallel word, sampled only on an accepted load
//   msb_first   in   bit order for the frame (1 = MSB first), sampled on accept
//   load_valid  in   din / msb_first are valid
//   load_ready  out  a word can be accepted this cycle (combinational)
//   sout        out  serial data bit (registered)
//   sout_valid  out  sout carries a frame bit (registered)
//   busy        out  a frame is in progress (registered)
//   done        out  one-cycle pulse on the last bit of a frame (registered)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         msb_first,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  // sreg holds only the bits not yet placed on sout. The first bit goes
  // straight into the sout flop at accept, which gives the one-cycle latency.
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           sout_q, sout_d;
  logic           sout_valid_q, sout_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef PISO_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic last_bit;
  logic accept;

  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif

    if (accept) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      dir_d        = msb_first;
      sout_valid_d = 1'b1;
      busy_d       = 1'b1;
      if (msb_first) begin
        sout_d = din[N-1];
        sreg_d = {din[N-2:0], 1'b0};
      end else begin
        sout_d = din[0];
        sreg_d = {1'b0, din[N-1:1]};
      end
`ifdef PISO_PARITY_EN
      parity_d = ^din;
`endif
    end else if (last_bit) begin
      // The frame has ended and no follow-on word is waiting, so go idle.
      state_d      = IDLE;
      cnt_d        = '0;
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
      busy_d       = 1'b0;
    end else if (state_q == SHIFT) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_d == LAST);
      if (dir_q) begin
        sout_d = sreg_q[N-1];
        sreg_d = {sreg_q[N-2:0], 1'b0};
      end else begin
        sout_d = sreg_q[0];
        sreg_d = {1'b0, sreg_q[N-1:1]};
      end
`ifdef PISO_PARITY_EN
      // Index N is the parity slot. It follows the data in either bit order.
      if (cnt_d == CW'(N)) begin
        sout_d = parity_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PISO_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Scoreboard bench for piso_serializer (N = 4).
//
//   When the bench's own ready model says a load is accepted, the expected
//   frame bits are pushed to a queue. Each negedge pops one expected bit and
//   compares it against sout, sout_valid, busy and done. The monitor also
//   compares load_ready against the model: ready whenever no bits remain
//   after the current one.
// -----------------------------------------------------------------------------
module tb_piso_serializer;
  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] din;
  logic         msb_first;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  exp_t sb[$];

  piso_serializer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .msb_first  (msb_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor and scoreboard. It samples at negedge; inputs only change 1 time
  // unit after posedge.
  logic has_bit;
  exp_t cur;
  logic ready_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      has_bit = (sb.size() > 0);
      cur     = '0;
      if (has_bit) cur = sb.pop_front();

      checks++;
      if (sout_valid !== has_bit) begin
        errors++;
        $display("FAIL sout_valid: got %b expected %b at %0t", sout_valid, has_bit, $time);
      end
      checks++;
      if (busy !== has_bit) begin
        errors++;
        $display("FAIL busy: got %b expected %b at %0t", busy, has_bit, $time);
      end
      checks++;
      if (sout !== cur.b) begin
        errors++;
        $display("FAIL sout: got %b expected %b at %0t", sout, cur.b, $time);
      end
      checks++;
      if (done !== cur.last) begin
        errors++;
        $display("FAIL done: got %b expected %b at %0t", done, cur.last, $time);
      end

      ready_exp = (sb.size() == 0);
      checks++;
      if (load_ready !== ready_exp) begin
        errors++;
        $display("FAIL load_ready: got %b expected %b at %0t", load_ready, ready_exp, $time);
      end

      if (load_valid && ready_exp) begin
        for (int i = 0; i < N; i++) begin
          exp_t e;
          e.b    = msb_first ? din[N-1-i] : din[i];
          e.last = (i == F - 1);
          sb.push_back(e);
        end
`ifdef PISO_PARITY_EN
        begin
          exp_t p;
          p.b    = ^din;
          p.last = 1'b1;
          sb.push_back(p);
        end
`endif
        acc_cnt++;
        $display("accept din=%b msb_first=%0d at %0t", din, msb_first, $time);
      end
    end
  end

  // Hold a word valid until the model accepts it. Returns 1 time unit after
  // the accept edge, with load_valid dropped.
  task automatic send(input logic [N-1:0] w, input logic m);
    int start;
    bit ok;
    start      = acc_cnt;
    ok         = 1'b0;
    din        = w;
    msb_first  = m;
    load_valid = 1'b1;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(posedge clk);
      if (acc_cnt != start) ok = 1'b1;
    end
    #1;
    load_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of %b", w);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00001", {sout, sout_valid, busy, done, load_ready});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_msb_first;
    send(4'b1011, 1'b1);
    idle_cycles(6);
  endtask

  task automatic test_lsb_first;
    send(4'b1011, 1'b0);
    // Toggling msb_first during the frame must not change the bit order.
    for (int c = 0; c < 4; c++) begin
      msb_first = ~msb_first;
      @(posedge clk);
      #1;
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back;
    send(4'b1011, 1'b1);
    send(4'b0110, 1'b1);
    idle_cycles(7);
  endtask

  task automatic test_backpressure;
    send(4'b1011, 1'b1);
    @(posedge clk);
    #1;
    din        = 4'b1111;
    msb_first  = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_ready: got %b expected 0", load_ready);
    end
    send(4'b1111, 1'b1);
    idle_cycles(7);
  endtask

  task automatic test_reset_mid_frame;
    send(4'b1101, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midframe_reset: got %b expected 00001", {sout, sout_valid, busy, done, load_ready});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    // The monitor now expects idle outputs; any leftover bit would show up.
    idle_cycles(5);
  endtask

  task automatic test_parity_zero;
    send(4'b0000, 1'b1);
    idle_cycles(6);
    send(4'b0111, 1'b0);
    idle_cycles(6);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle_cycles(8);
  endtask

  initial begin
    rst_n      = 1'b1;
    din        = '0;
    msb_first  = 1'b0;
    load_valid = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_parity_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
